// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins each forced low, static high or driven by one shared 8-bit PWM.
// Latency: enable change -> pin 1 clk; counter change -> pin 1 clk. No backpressure.
// Optional PWM_SYNC_UPDATE_EN: duty loads only at period wrap instead of every clk.
module pwm_peripheral #(
  parameter int unsigned PRESCALE   = 13,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       period_start
);

  if (PRESCALE < 1 || PRESCALE > (1 << PRESCALE_W)) begin : g_bad_prescale
    $error("pwm_peripheral: PRESCALE must be in 1..2**PRESCALE_W");
  end

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [7:0]            pwm_cnt;
  logic [7:0]            duty_sh;
  logic                  tick;
  logic                  wrap;
  logic                  pwm_raw;
  logic [15:0]           en_out;
  logic [15:0]           en_pwm;
  logic [15:0]           pin_nxt;

  assign tick    = (pre_cnt == PRESCALE_W'(PRESCALE - 1));
  assign wrap    = tick && (pwm_cnt == 8'hFF);
  // 0xFF is forced high so full duty has no single low step per period.
  assign pwm_raw = (duty_sh == 8'hFF) | (pwm_cnt < duty_sh);
  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pin_nxt = en_out & (~en_pwm | {16{pwm_raw}});

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      pre_cnt      <= tick ? '0 : pre_cnt + 1'b1;
      period_start <= wrap;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh <= '0;
    end else if (wrap) begin
      duty_sh <= pwm_duty_cycle;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh <= '0;
    end else begin
      duty_sh <= pwm_duty_cycle;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
    end else begin
      uo_out  <= pin_nxt[7:0];
      uio_out <= pin_nxt[15:8];
      uio_oe  <= en_reg_out_15_8;
    end
  end

endmodule
